// File: rtl/host_mem_port.sv
// host_mem_port: byte-wide host responder for halted-core memory access.
// The host sends framed commands on ui_in with a strobe on uio_in[0]:
//   write: A5, addr_hi, addr_lo, data [, checksum]
//   read : 5A, addr_hi, addr_lo
// Each frame produces one single-byte access on the mem_* port, and the host
// sees completion as a toggle on uio_out[1].
// Optional feature macro: HOST_MEM_PORT_CSUM_EN adds a trailing XOR checksum
// byte to write frames.
//
// Handshake: a host byte is taken in any cycle where ena is high, strobe is
// high and the strobe was low in the previous enabled cycle (rising edge).
// mem_we and mem_re are single-cycle pulses; mem_rdata is sampled only in a
// cycle where mem_rvalid is high while the port is waiting for read data.
module host_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              cpu_halt,
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WDATA,
`ifdef HOST_MEM_PORT_CSUM_EN
    S_CSUM,
`endif
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_OP_WRITE = 8'hA5;
  localparam logic [7:0] LP_OP_READ  = 8'h5A;
  localparam logic [7:0] LP_CNT_MAX  = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_strb_q;
  logic                r_is_read;
  logic [7:0]          r_addr_hi;
  logic [7:0]          r_uo;
  logic                r_ack;
  logic                r_busy;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                r_we;
  logic                r_re;
  logic [7:0]          r_cnt;
`ifdef HOST_MEM_PORT_CSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_accept;
  logic                w_unused;

  // Rising edge of the host strobe while the design is selected.
  assign w_accept = ena & uio_in[0] & ~r_strb_q;

  // Upper uio_in bits carry nothing for this block.
  assign w_unused = ^uio_in[7:1];

  // Memory strobes are suppressed whenever the design is deselected; the
  // registered request is kept so the access still happens after ena returns.
  assign mem_we      = r_we & ena;
  assign mem_re      = r_re & ena;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign uo_out      = r_uo;
  assign uio_out     = {4'b0000, r_err, r_busy, r_ack, 1'b0};
  assign uio_oe      = 8'b0000_1110;
  assign cpu_halt    = r_busy;
  assign o_dbg_state = r_state;

  // Frame decoder, access sequencer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_strb_q  <= 1'b0;
      r_is_read <= 1'b0;
      r_addr_hi <= 8'h00;
      r_uo      <= 8'h00;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_cnt     <= 8'h00;
`ifdef HOST_MEM_PORT_CSUM_EN
      r_csum    <= 8'h00;
`endif
    end else if (ena) begin
      r_strb_q <= uio_in[0];
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ui_in == LP_OP_WRITE || ui_in == LP_OP_READ) begin
              r_is_read <= (ui_in == LP_OP_READ);
              r_err     <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_ADDR_HI;
`ifdef HOST_MEM_PORT_CSUM_EN
              r_csum    <= ui_in;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ADDR_HI: begin
          if (w_accept) begin
            r_addr_hi <= ui_in;
            r_state   <= S_ADDR_LO;
`ifdef HOST_MEM_PORT_CSUM_EN
            r_csum    <= r_csum ^ ui_in;
`endif
          end
        end
        S_ADDR_LO: begin
          if (w_accept) begin
            r_addr <= ADDR_W'({r_addr_hi, ui_in});
`ifdef HOST_MEM_PORT_CSUM_EN
            r_csum <= r_csum ^ ui_in;
`endif
            if (r_is_read) begin
              r_re    <= 1'b1;
              r_state <= S_READ_REQ;
            end else begin
              r_state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (w_accept) begin
            r_wdata <= ui_in;
`ifdef HOST_MEM_PORT_CSUM_EN
            r_csum  <= r_csum ^ ui_in;
            r_state <= S_CSUM;
`else
            r_we    <= 1'b1;
            r_state <= S_WRITE;
`endif
          end
        end
`ifdef HOST_MEM_PORT_CSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            if (ui_in == r_csum) begin
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`endif
        S_WRITE: begin
          r_state <= S_DONE;
        end
        S_READ_REQ: begin
          r_cnt   <= 8'h00;
          r_state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (mem_rvalid) begin
            r_uo    <= mem_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_uo    <= 8'hFF;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_ack   <= ~r_ack;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_port.sv
// tb_host_mem_port: randomized frames against a transaction-level model.
// The model predicts, per frame, the cycle and content of the memory strobe
// and of the ack toggle from the frame timing rules; a per-cycle monitor
// compares the DUT against those predictions.
`timescale 1ns/1ps
module tb_host_mem_port;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic [7:0]        ui_in = 8'h00;
  logic [7:0]        uio_in = 8'h00;
  logic [7:0]        uo_out;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_rvalid = 1'b0;
  logic              cpu_halt;
  logic [3:0]        o_dbg_state;

  host_mem_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .cpu_halt(cpu_halt), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  mem_model [256];
  logic [47:0] we_q[$];   // {cycle, addr, data}
  logic [39:0] re_q[$];   // {cycle, addr}
  logic [40:0] ack_q[$];  // {cycle, uo_out, err}
  logic        m_busy = 1'b0;
  logic        m_err = 1'b0;
  logic [7:0]  m_uo = 8'h00;
  logic        prev_ack = 1'b0;
  logic        mon_on = 1'b0;
  int          rd_delay = 0;
  int          last_we_cyc = 0;
  int          last_re_cyc = 0;
  int          last_ack_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic [47:0] we_e;
  logic [39:0] re_e;
  logic [40:0] ack_e;
  logic        exp_ack;
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (we_q.size() != 0 && we_q[0][47:16] == cyc) begin
        we_e = we_q.pop_front();
        chk("we_pulse", mem_we, 1);
        chk("we_addr", mem_addr, we_e[15:8]);
        chk("we_data", mem_wdata, we_e[7:0]);
        last_we_cyc = cyc;
      end else begin
        chk("we_idle", mem_we, 0);
      end
      if (re_q.size() != 0 && re_q[0][39:8] == cyc) begin
        re_e = re_q.pop_front();
        chk("re_pulse", mem_re, 1);
        chk("re_addr", mem_addr, re_e[7:0]);
        last_re_cyc = cyc;
      end else begin
        chk("re_idle", mem_re, 0);
      end
      if (ack_q.size() != 0 && ack_q[0][40:9] == cyc) begin
        ack_e = ack_q.pop_front();
        exp_ack = ~prev_ack;
        chk("ack_toggle", uio_out[1], exp_ack);
        chk("uo_at_ack", uo_out, ack_e[8:1]);
        chk("err_at_ack", uio_out[3], ack_e[0]);
        m_busy = 1'b0;
        m_uo = ack_e[8:1];
        m_err = ack_e[0];
        last_ack_cyc = cyc;
      end else begin
        chk("ack_hold", uio_out[1], prev_ack);
      end
      prev_ack = uio_out[1];
      chk("busy", uio_out[2], m_busy);
      chk("cpu_halt", cpu_halt, m_busy);
      chk("uio_oe", uio_oe, 8'h0E);
      chk("uio_spare", {uio_out[7:4], uio_out[0]}, 5'd0);
    end
  end

  // ---------------- memory responder ----------------
  logic [7:0] rsp_addr;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ena && mem_re && rd_delay != 0) begin
        rsp_addr = mem_addr;
        @(posedge clk); #1;
        for (int k = 1; k < rd_delay; k++) begin
          mem_rdata = 8'($urandom);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata = mem_model[rsp_addr];
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int hold, input bit is_op, output int acc);
    @(posedge clk); #1;
    ui_in = b;
    uio_in[7:1] = 7'($urandom);
    uio_in[0] = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    if (is_op) begin
      m_busy = 1'b1;
      m_err = 1'b0;
    end
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
    end
    uio_in[0] = 1'b0;
    ui_in = 8'($urandom);
  endtask

  task automatic ena_pause(input int n);
    ena = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      uio_in[0] = (k % 2 == 0);
      ui_in = 8'($urandom);
    end
    uio_in[0] = 1'b0;
    @(posedge clk); #1;
    ena = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (ack_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (ack_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_wait: %0d acks still pending, expected 0", ack_q.size());
      ack_q.delete(); we_q.delete(); re_q.delete();
      m_busy = 1'b0;
    end
    @(negedge clk);
    chk("err_after_frame", uio_out[3], m_err);
    chk("busy_after_frame", uio_out[2], 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] d,
                          input int hold, input bit ena_gap, input bit extra, input bit bad_csum);
    int a;
    int a2;
    bit bad;
    logic [15:0] full;
    logic [7:0] ad;
    full = {hi, lo};
    ad = 8'(full[ADDR_W-1:0]);
    bad = 1'b0;
    send_byte(8'hA5, hold, 1, a);
    send_byte(hi, 1, 0, a);
    if (ena_gap) ena_pause(10);
    send_byte(lo, 1, 0, a);
    send_byte(d, 1, 0, a);
`ifdef HOST_MEM_PORT_CSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'hA5 ^ hi ^ lo ^ d;
      bad = bad_csum;
      if (bad) cs = (cs == 8'h00) ? 8'h01 : 8'h00;
      send_byte(cs, 1, 0, a);
    end
`endif
    if (bad) begin
      ack_q.push_back({32'(a + 2), m_uo, 1'b1});
    end else begin
      we_q.push_back({32'(a + 1), ad, d});
      ack_q.push_back({32'(a + 3), m_uo, 1'b0});
      mem_model[ad] = d;
      if (extra && bad_csum == 1'b0) send_byte(8'h00, 1, 0, a2);
    end
    wait_done();
  endtask

  task automatic do_read(input logic [7:0] hi, input logic [7:0] lo, input int d, input bit extra);
    int a;
    int a2;
    int r;
    logic [15:0] full;
    logic [7:0] ad;
    full = {hi, lo};
    ad = 8'(full[ADDR_W-1:0]);
    send_byte(8'h5A, 1, 1, a);
    send_byte(hi, 1, 0, a);
    rd_delay = d;
    send_byte(lo, 1, 0, a);
    r = a + 1;
    re_q.push_back({32'(r), ad});
    if (d >= 1 && d <= TIMEOUT) ack_q.push_back({32'(r + d + 2), mem_model[ad], 1'b0});
    else ack_q.push_back({32'(r + TIMEOUT + 2), 8'hFF, 1'b1});
    if (extra) send_byte(8'h00, 1, 0, a2);
    wait_done();
  endtask

  task automatic do_bad_op(input logic [7:0] b);
    int a;
    send_byte(b, 1, 0, a);
    m_err = 1'b1;
    @(negedge clk);
    chk("bad_op_err", uio_out[3], m_err);
    chk("bad_op_busy", uio_out[2], 0);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int op;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h0E);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_cpu_halt", cpu_halt, 0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Unknown opcode: error without busy, ack untouched.
    do_bad_op(8'h00);
    chk("bad_op_ack", uio_out[1], 0);

    // Directed write A5,00,12,3C.
    do_write(8'h00, 8'h12, 8'h3C, 1, 0, 0, 0);
    chk("wr_addr_lit", mem_addr, 8'h12);
    chk("wr_data_lit", mem_wdata, 8'h3C);
    chk("wr_ack_lit", uio_out[1], 1);
    chk("wr_we_to_ack", last_ack_cyc - last_we_cyc, 2);

    // Directed read of the same location, data after 3 cycles.
    do_read(8'h00, 8'h12, 3, 0);
    chk("rd_data_lit", uo_out, 8'h3C);
    chk("rd_err_lit", uio_out[3], 0);
    chk("rd_ack_lit", uio_out[1], 0);

    // Read that never gets data.
    do_read(8'h00, 8'h40, 0, 0);
    chk("to_data_lit", uo_out, 8'hFF);
    chk("to_err_lit", uio_out[3], 1);
    chk("to_re_to_ack", last_ack_cyc - last_re_cyc, 18);

    // Opcode strobe held high for 5 cycles, then ena gap mid-frame.
    do_write(8'h00, 8'h21, 8'h77, 5, 0, 0, 0);
    do_write(8'h01, 8'h22, 8'h99, 1, 1, 0, 0);
    chk("gap_addr_lit", mem_addr, 8'h22);
    do_read(8'h01, 8'h22, 2, 0);
    chk("gap_rd_lit", uo_out, 8'h99);

    // Strobes during the access phase are dropped silently.
    do_write(8'h00, 8'h30, 8'h5C, 1, 0, 1, 0);
    do_read(8'h00, 8'h30, 1, 1);

`ifdef HOST_MEM_PORT_CSUM_EN
    do_write(8'h00, 8'h12, 8'h3C, 1, 0, 0, 0);
    do_write(8'h00, 8'h12, 8'h3C, 1, 0, 0, 1);
    chk("csum_bad_err", uio_out[3], 1);
`endif

    // Reset after addr_hi: no access, back to idle.
    begin
      int a;
      send_byte(8'hA5, 1, 1, a);
      send_byte(8'h00, 1, 0, a);
      rst_n = 1'b0;
      m_busy = 1'b0; m_err = 1'b0; m_uo = 8'h00; prev_ack = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_busy", uio_out[2], 0);
      chk("midrst_uio_out", uio_out, 8'h00);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_state", o_dbg_state, 4'd0);
      repeat (3) @(posedge clk);
      #1;
    end
    do_read(8'h00, 8'h12, 4, 0);

    // Randomized frames.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_write(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
      end else if (op <= 8) begin
        do_read(8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT + 2),
                ($urandom_range(0, 3) == 0));
      end else begin
        b = 8'($urandom);
        if (b == 8'hA5 || b == 8'h5A) b = 8'h3C;
        do_bad_op(b);
      end
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
